result_out_port: RTL and testbench
==================================

# result_out_port

Parametrised output stage between the processor's `result` bus and the board output pins. It replaces the fixed "register the top byte every clock" output. It can:

- present any `OUT_W`-bit slice of a `DATA_W`-bit result (static mode), or
- snapshot a result and scan all slices onto the narrow port, MSB slice first, each held for a programmable dwell, with strobe and busy signalling (scan and change modes).

It sits in the machine top level, fed by the processor, and drives the external output.

## Interface

Parameters:

- `DATA_W`, 32, width of the result bus; must be an integer multiple of `OUT_W`.
- `OUT_W`, 8, width of the output port. `SLICES = DATA_W/OUT_W`, `IW = max(1, $clog2(SLICES))`.
- `HOLD`, 4, cycles each slice is held during a scan; must be >= 1.

Ports:

- `clk`, in, 1, single clock, all state on rising edge.
- `rst_n`, in, 1, one clock; reset is asynchronous and active-low.
- `result`, in, DATA_W, live processor result.
- `result_valid`, in, 1, capture request (used in scan mode only).
- `mode`, in, 2. Values: 0 = STATIC, 1 = SCAN, 2 = CHANGE, 3 = treated as STATIC.
- `sel`, in, IW, slice index for STATIC. Index 0 = bits `[OUT_W-1:0]`; `SLICES-1` = top slice.
- `out`, out, OUT_W, registered output slice.
- `out_idx`, out, IW, slice index currently on `out`.
- `out_strobe`, out, 1, one-cycle pulse on the first cycle of each scanned slice.
- `busy`, out, 1, high while a scan is in progress.

## Operation

- Reset (async, `rst_n`=0) sets all of the following to 0: `out`, `out_idx`, `out_strobe`, `busy`, snapshot, pending flag, pending data, slice counter, hold counter. State goes to IDLE.
- States: IDLE, SHOW.
- STATIC (mode 0/3):
  - State stays IDLE.
  - Every cycle: `out <= result[sel*OUT_W +: OUT_W]`, `out_idx <= sel`.
  - `out_strobe` = 0, `busy` = 0.
  - Legacy behaviour is `sel = SLICES-1`.
- SCAN (mode 1), starting a scan:
  - In IDLE with `result_valid`=1, capture `result` into the snapshot.
  - Enter SHOW with slice counter = `SLICES-1` and hold counter = `HOLD-1`.
- CHANGE (mode 2):
  - Same as SCAN, but the trigger is `result != snapshot`, evaluated every cycle; `result_valid` is ignored.
  - After reset the snapshot is 0, so a zero result never triggers.
- SHOW, each cycle:
  - `out = snapshot slice[slice counter]`, `out_idx` = slice counter, `busy` = 1.
  - `out_strobe` = 1 only on the first cycle of each slice.
  - The hold counter decrements. At 0 it reloads `HOLD-1` and the slice counter decrements.
- End of scan: when the slice counter is 0 and the hold counter is 0 (last cycle):
  - If a trigger is present in this cycle, or the pending flag is set: load the snapshot (current `result` if triggered now, else pending data), clear pending, and restart SHOW at the top slice with no gap.
  - Otherwise go to IDLE.
  - In IDLE, `out` and `out_idx` keep the last slice shown.
- Triggers during SHOW (other than the last cycle): set the pending flag and store `result` in pending data.
  - One-deep buffer; the newest trigger overwrites older pending data.
  - In CHANGE mode the comparison is against the snapshot being shown.
- `mode` change while in SHOW: return to IDLE on the next edge and clear the pending flag. `busy` and `out_strobe` go to 0.
  - If the new mode is STATIC, `out` follows `sel` from that edge.

## Timing

- STATIC: `out` reflects `result`/`sel` one cycle after they are presented.
- Scan start: with trigger at edge N, edge N+1 gives `out` = top slice, `out_idx` = `SLICES-1`, `out_strobe` = 1, `busy` = 1.
- Scan duration:
  - Exactly `SLICES*HOLD` cycles of `busy`=1.
  - Strobes fall at cycles N+1, N+1+HOLD, ..., N+1+(SLICES-1)*HOLD.
- Back-to-back scans: `busy` stays 1 with no idle cycle; the next strobe follows the last slice by exactly HOLD cycles.
- Reset mid-scan: outputs are 0 immediately on the `rst_n` fall, with no clock needed. After release the block is IDLE.

## Test plan

All scenarios use `DATA_W`=32, `OUT_W`=8, `HOLD`=4.

- Static slice select: mode 0, `result`=0xA1B2C3D4.
  - `sel`=3 gives `out`=0xA1 one cycle later.
  - `sel`=0 gives 0xD4.
  - `busy`=0 and `out_strobe`=0 throughout.
- Single scan: mode 1, `result`=0x12345678, `result_valid` pulsed 1 cycle.
  - `out` = 0x12, 0x34, 0x56, 0x78, 4 cycles each.
  - `out_idx` = 3, 2, 1, 0; strobes at +1, +5, +9, +13.
  - `busy` high 16 cycles, then `out` holds 0x78.
- Pending overwrite: during the scan of 0x12345678, valid with 0xCAFEF00D at +6, then 0xDEADBEEF at +8.
  - The next scan starts at +17 with no gap and shows 0xDE, 0xAD, 0xBE, 0xEF.
  - 0xCAFEF00D is never shown.
- Change mode: mode 2 after reset with `result`=0: no scan.
  - `result`=0x00000001 triggers one scan: 0x00, 0x00, 0x00, 0x01.
  - `result` held steady gives no retrigger.
- Mode abort: switch mode 1→0 at +6 of a scan with a pending capture.
  - `busy`=0 next cycle and `out` follows `sel`.
  - Returning to mode 1 without `result_valid` starts no scan.
- Async reset: assert `rst_n`=0 mid-scan between clock edges.
  - `out`, `out_idx`, `out_strobe`, `busy` are 0 immediately.
  - After release, first `result_valid` scans normally.

Source files
------------

// File: rtl/result_out_port_if.sv
// Handshake/bus bundle between the processor result side and the output stage.
// master: processor/board side (drives result, result_valid, mode, sel).
// slave : result_out_port (drives out, out_idx, out_strobe, busy).
interface result_out_port_if #(
    parameter int DATA_W = 32,
    parameter int OUT_W  = 8
);
    localparam int SLICES = DATA_W / OUT_W;
    localparam int IW     = (SLICES > 1) ? $clog2(SLICES) : 1;

    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic [1:0]        mode;
    logic [IW-1:0]     sel;
    logic [OUT_W-1:0]  out;
    logic [IW-1:0]     out_idx;
    logic              out_strobe;
    logic              busy;

    modport master (
        output result, result_valid, mode, sel,
        input  out, out_idx, out_strobe, busy
    );

    modport slave (
        input  result, result_valid, mode, sel,
        output out, out_idx, out_strobe, busy
    );
endinterface

// File: rtl/result_out_port.sv
// Output stage: presents a selected slice of the result bus, or scans a snapshot MSB slice first.
// Latency: one cycle from result/sel (static) or from the capture edge to the first scanned slice.
// Backpressure: none; a trigger during a scan is held in a one-deep overwrite buffer.
//
// Ports: clk, rst_n (async active-low); bus (slave modport):
//   result/result_valid/mode/sel in; out/out_idx/out_strobe/busy out (all registered).
module result_out_port #(
    parameter int DATA_W = 32,
    parameter int OUT_W  = 8,
    parameter int HOLD   = 4
) (
    input logic              clk,
    input logic              rst_n,
    result_out_port_if.slave bus
);
    localparam int SLICES = DATA_W / OUT_W;
    localparam int IW     = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int HW     = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [IW-1:0] TOP     = IW'(SLICES - 1);
    localparam logic [HW-1:0] HOLD_M1 = HW'(HOLD - 1);
    localparam logic [1:0]    M_SCAN   = 2'd1;
    localparam logic [1:0]    M_CHANGE = 2'd2;

    typedef logic [SLICES-1:0][OUT_W-1:0] slices_t;
    typedef enum logic {IDLE, SHOW} state_t;

    state_t            state;
    logic [DATA_W-1:0] snap;
    logic [DATA_W-1:0] pend_dat;
    logic              pend;
    logic [1:0]        act_mode;   // mode that launched the current scan
    logic [IW-1:0]     slice_cnt;
    logic [HW-1:0]     hold_cnt;

    logic [OUT_W-1:0]  out_q;
    logic [IW-1:0]     idx_q;
    logic              strobe_q;
    logic              busy_q;

    slices_t res_s;
    slices_t snap_s;
    logic    is_static;
    logic    trig;
    logic    last;

    assign res_s  = bus.result;
    assign snap_s = snap;

    assign is_static = (bus.mode != M_SCAN) && (bus.mode != M_CHANGE);
    // CHANGE compares against the snapshot currently held, which is the one being shown in SHOW.
    assign trig = ((bus.mode == M_SCAN) && bus.result_valid) ||
                  ((bus.mode == M_CHANGE) && (bus.result != snap));
    assign last = (slice_cnt == '0) && (hold_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            snap      <= '0;
            pend_dat  <= '0;
            pend      <= 1'b0;
            act_mode  <= 2'd0;
            slice_cnt <= '0;
            hold_cnt  <= '0;
            out_q     <= '0;
            idx_q     <= '0;
            strobe_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    strobe_q <= 1'b0;
                    busy_q   <= 1'b0;
                    if (is_static) begin
                        out_q <= res_s[bus.sel];
                        idx_q <= bus.sel;
                    end else if (trig) begin
                        snap      <= bus.result;
                        act_mode  <= bus.mode;
                        slice_cnt <= TOP;
                        hold_cnt  <= HOLD_M1;
                        state     <= SHOW;
                    end
                end

                SHOW: begin
                    if (bus.mode != act_mode) begin
                        // Mode switched under a scan: abandon it and any queued capture.
                        state    <= IDLE;
                        pend     <= 1'b0;
                        strobe_q <= 1'b0;
                        busy_q   <= 1'b0;
                        if (is_static) begin
                            out_q <= res_s[bus.sel];
                            idx_q <= bus.sel;
                        end
                    end else begin
                        out_q    <= snap_s[slice_cnt];
                        idx_q    <= slice_cnt;
                        busy_q   <= 1'b1;
                        strobe_q <= (hold_cnt == HOLD_M1);
                        if (last) begin
                            if (trig || pend) begin
                                // Chain straight into the next scan so busy never drops.
                                snap      <= trig ? bus.result : pend_dat;
                                pend      <= 1'b0;
                                slice_cnt <= TOP;
                                hold_cnt  <= HOLD_M1;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            if (trig) begin
                                pend     <= 1'b1;
                                pend_dat <= bus.result;
                            end
                            if (hold_cnt == '0) begin
                                hold_cnt  <= HOLD_M1;
                                slice_cnt <= slice_cnt - 1'b1;
                            end else begin
                                hold_cnt <= hold_cnt - 1'b1;
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out        = out_q;
    assign bus.out_idx    = idx_q;
    assign bus.out_strobe = strobe_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_result_out_port.sv
module tb_result_out_port;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    result_out_port_if #(.DATA_W(32), .OUT_W(8)) bus ();

    result_out_port #(.DATA_W(32), .OUT_W(8), .HOLD(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Follows one complete scan whose capture edge has just passed; b3 is the top byte.
    task automatic scan_check(input string tg, input logic [7:0] b3, input logic [7:0] b2,
                              input logic [7:0] b1, input logic [7:0] b0);
        logic [7:0] exp_b [4];
        exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2; exp_b[3] = b3;
        for (int k = 1; k <= 16; k++) begin
            int s;
            s = 3 - (k - 1) / 4;
            tick();
            check({tg, "_out"},    32'(bus.out),        32'(exp_b[s]));
            check({tg, "_idx"},    32'(bus.out_idx),    32'(s));
            check({tg, "_strobe"}, 32'(bus.out_strobe), ((k - 1) % 4 == 0) ? 32'd1 : 32'd0);
            check({tg, "_busy"},   32'(bus.busy),       32'd1);
        end
        tick();
        check({tg, "_end_busy"},   32'(bus.busy),       32'd0);
        check({tg, "_end_strobe"}, 32'(bus.out_strobe), 32'd0);
        check({tg, "_end_out"},    32'(bus.out),        32'(b0));
        check({tg, "_end_idx"},    32'(bus.out_idx),    32'd0);
    endtask

    initial begin
        logic [7:0] exp_p [8];
        exp_p = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        n_chk  = 0;
        n_fail = 0;

        // Reset state
        rst_n            = 1'b0;
        bus.result       = 32'h0;
        bus.result_valid = 1'b0;
        bus.mode         = 2'd0;
        bus.sel          = 2'd0;
        #2;
        check("rst_out",    32'(bus.out),        32'd0);
        check("rst_idx",    32'(bus.out_idx),    32'd0);
        check("rst_strobe", 32'(bus.out_strobe), 32'd0);
        check("rst_busy",   32'(bus.busy),       32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Static slice select
        bus.result = 32'hA1B2C3D4;
        bus.sel = 2'd3; tick();
        check("st3_out", 32'(bus.out), 32'hA1);
        check("st3_idx", 32'(bus.out_idx), 32'd3);
        check("st3_busy", 32'(bus.busy), 32'd0);
        check("st3_strobe", 32'(bus.out_strobe), 32'd0);
        bus.sel = 2'd0; tick();
        check("st0_out", 32'(bus.out), 32'hD4);
        check("st0_idx", 32'(bus.out_idx), 32'd0);
        bus.sel = 2'd1; tick();
        check("st1_out", 32'(bus.out), 32'hC3);
        bus.sel = 2'd2; bus.mode = 2'd3; tick();
        check("st2_mode3_out", 32'(bus.out), 32'hB2);
        check("st2_mode3_busy", 32'(bus.busy), 32'd0);

        // Single scan
        bus.mode = 2'd1; bus.result = 32'h12345678; bus.result_valid = 1'b1;
        tick();
        bus.result_valid = 1'b0;
        check("scan_cap_busy", 32'(bus.busy), 32'd0);
        scan_check("scan", 8'h12, 8'h34, 8'h56, 8'h78);
        tick();
        check("scan_hold_out", 32'(bus.out), 32'h78);
        check("scan_hold_busy", 32'(bus.busy), 32'd0);

        // Pending overwrite, back-to-back scans
        bus.result = 32'h12345678; bus.result_valid = 1'b1;
        tick();
        bus.result_valid = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            int q;
            q = (k - 1) / 4;
            if (k == 6) begin bus.result = 32'hCAFEF00D; bus.result_valid = 1'b1; end
            else if (k == 8) begin bus.result = 32'hDEADBEEF; bus.result_valid = 1'b1; end
            else bus.result_valid = 1'b0;
            tick();
            check("pend_out",    32'(bus.out),        32'(exp_p[q]));
            check("pend_idx",    32'(bus.out_idx),    32'(3 - (q % 4)));
            check("pend_strobe", 32'(bus.out_strobe), ((k - 1) % 4 == 0) ? 32'd1 : 32'd0);
            check("pend_busy",   32'(bus.busy),       32'd1);
        end
        tick();
        check("pend_end_busy", 32'(bus.busy), 32'd0);
        check("pend_end_out",  32'(bus.out),  32'hEF);

        // Change mode from a fresh reset
        #3; rst_n = 1'b0;
        bus.mode = 2'd2; bus.result = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("chg_zero_busy", 32'(bus.busy), 32'd0);
        end
        bus.result = 32'h00000001;
        tick();
        scan_check("chg", 8'h00, 8'h00, 8'h00, 8'h01);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("chg_steady_busy", 32'(bus.busy), 32'd0);
            check("chg_steady_out",  32'(bus.out),  32'h01);
        end

        // Mode abort with a pending capture
        bus.mode = 2'd1; bus.result = 32'h12345678; bus.result_valid = 1'b1;
        tick();
        for (int k = 1; k <= 5; k++) begin
            if (k == 3) begin bus.result = 32'hAABBCCDD; bus.result_valid = 1'b1; end
            else bus.result_valid = 1'b0;
            tick();
            if (k == 1) check("abort_first_out", 32'(bus.out), 32'h12);
            if (k == 5) check("abort_k5_out", 32'(bus.out), 32'h34);
        end
        bus.mode = 2'd0; bus.sel = 2'd2; bus.result = 32'hA1B2C3D4;
        tick();
        check("abort_busy",   32'(bus.busy),       32'd0);
        check("abort_strobe", 32'(bus.out_strobe), 32'd0);
        check("abort_out",    32'(bus.out),        32'hB2);
        check("abort_idx",    32'(bus.out_idx),    32'd2);
        bus.sel = 2'd0;
        tick();
        check("abort_sel0_out", 32'(bus.out), 32'hD4);
        bus.mode = 2'd1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("abort_noscan_busy", 32'(bus.busy), 32'd0);
            check("abort_noscan_out",  32'(bus.out),  32'hD4);
        end

        // Async reset mid-scan
        bus.result = 32'h12345678; bus.result_valid = 1'b1;
        tick();
        bus.result_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        #2; rst_n = 1'b0; #1;
        check("arst_out",    32'(bus.out),        32'd0);
        check("arst_idx",    32'(bus.out_idx),    32'd0);
        check("arst_strobe", 32'(bus.out_strobe), 32'd0);
        check("arst_busy",   32'(bus.busy),       32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        bus.result = 32'h0F1E2D3C; bus.result_valid = 1'b1;
        tick();
        bus.result_valid = 1'b0;
        scan_check("post_rst", 8'h0F, 8'h1E, 8'h2D, 8'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
